// File: rtl/axis_keep_downsizer_pkg.sv
// Shared helpers for keep-aware AXI-Stream blocks: lowest-set-lane lookup
// and one-hot detection over a lane mask of up to MAX_LANES lanes.
package axis_keep_downsizer_pkg;

  localparam int MAX_LANES = 64;

  typedef logic [MAX_LANES-1:0] lane_mask_t;

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic int lowest_set_index(input lane_mask_t mask);
    int idx;
    idx = 0;
    for (int i = MAX_LANES - 1; i >= 0; i--) begin
      if (mask[i]) idx = i;
    end
    return idx;
  endfunction

  // True when exactly one bit of the mask is set.
  function automatic logic is_onehot(input lane_mask_t mask);
    return (mask != '0) && ((mask & (mask - lane_mask_t'(1))) == '0);
  endfunction

endpackage

// File: rtl/axis_if.sv
// AXI-Stream style handshake bundle; ok marks a completed transfer.
interface Axis_If #(
  parameter int W = 8
);
  logic [W-1:0] data;
  logic         valid;
  logic         ready;
  logic         last;
  logic         ok;

  assign ok = valid & ready;

  modport Slave_Full (
    input  data,
    input  valid,
    input  last,
    input  ok,
    output ready
  );

  modport Master_Full (
    output data,
    output valid,
    output last,
    input  ready,
    input  ok
  );
endinterface

// File: rtl/lsb_priority_encoder.sv
// Lowest-set-bit priority encoder with "any bit set" and "exactly one bit
// set" flags, built on the shared package helpers.
module lsb_priority_encoder
  import axis_keep_downsizer_pkg::*;
#(
  parameter  int N  = 8,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          any,
  output logic          single
);

  lane_mask_t req_ext;

  assign req_ext = lane_mask_t'(req);
  assign idx     = IW'(lowest_set_index(req_ext));
  assign any     = |req;
  assign single  = is_onehot(req_ext);

endmodule

// File: rtl/axis_keep_downsizer.sv
// Splits each wide input word into its kept sub-words, emitted lowest index
// first, one per cycle. A word whose keep is all zero produces no output;
// if it carried last, empty_last pulses for one cycle instead.
module axis_keep_downsizer
  import axis_keep_downsizer_pkg::*;
#(
  parameter int DWIDTH = 16,
  parameter int DOWN   = 8
) (
  input  logic            clk,
  input  logic            reset,
  Axis_If.Slave_Full      data_in,
  input  logic [DOWN-1:0] data_in_keep,
  Axis_If.Master_Full     data_out,
  output logic            empty_last
);

  localparam int IW = (DOWN > 1) ? $clog2(DOWN) : 1;

  logic [DOWN-1:0][DWIDTH-1:0] data_reg;
  logic [DOWN-1:0]             mask_reg;
  logic                        last_reg;
  logic                        empty_last_reg;

  logic [IW-1:0] idx;
  logic          any;
  logic          single;

  lsb_priority_encoder #(
    .N (DOWN)
  ) u_lsb_priority_encoder (
    .req    (mask_reg),
    .idx    (idx),
    .any    (any),
    .single (single)
  );

  // A new word may enter when nothing is pending, or when the last pending
  // sub-word leaves this cycle (gives back-to-back words with no bubble).
  assign data_in.ready  = ~any | (single & data_out.ready);

  assign data_out.valid = any;
  assign data_out.data  = data_reg[idx];
  assign data_out.last  = last_reg & single & any;
  assign empty_last     = empty_last_reg;

  // Word holding register: load on input transfer (wins over the final
  // output transfer), otherwise retire the lane just sent.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_reg       <= '0;
      mask_reg       <= '0;
      last_reg       <= 1'b0;
      empty_last_reg <= 1'b0;
    end else begin
      empty_last_reg <= data_in.ok & (data_in_keep == '0) & data_in.last;
      if (data_in.ok) begin
        data_reg <= data_in.data;
        mask_reg <= data_in_keep;
        last_reg <= data_in.last;
      end else if (data_out.ok) begin
        mask_reg[idx] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_keep_downsizer.sv
// Bench for axis_keep_downsizer: directed scenarios plus a randomized run
// against a queue-based reference of kept sub-words.
module tb_axis_keep_downsizer;

  localparam int DWIDTH = 16;
  localparam int DOWN   = 8;
  localparam int NWORDS = 1000;

  logic            clk = 1'b0;
  logic            reset;
  logic [DOWN-1:0] keep;
  logic            empty_last;

  Axis_If #(.W(DWIDTH*DOWN)) in_if ();
  Axis_If #(.W(DWIDTH))      out_if ();

  always #5 clk = ~clk;

  axis_keep_downsizer #(
    .DWIDTH (DWIDTH),
    .DOWN   (DOWN)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .data_in      (in_if),
    .data_in_keep (keep),
    .data_out     (out_if),
    .empty_last   (empty_last)
  );

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic [DWIDTH:0] exp_q[$];
  int n_in_last  = 0;
  int n_in_empty = 0;
  int n_out_last = 0;
  int n_el       = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_word(input logic [15:0] base, input logic [DOWN-1:0] k, input logic l);
    for (int i = 0; i < DOWN; i++) in_if.data[i*DWIDTH +: DWIDTH] = base + 16'(i);
    keep        = k;
    in_if.last  = l;
    in_if.valid = 1'b1;
  endtask

  // Monitor / scoreboard: every accepted word expands into its kept
  // sub-words; every output transfer must match the queue head.
  initial begin : monitor
    logic            exp_el;
    logic [DWIDTH:0] head;
    int              hi;
    exp_el = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        exp_el = 1'b0;
      end else begin
        check("empty_last", empty_last, exp_el);
        if (empty_last) n_el++;
        exp_el = 1'b0;
        if (in_if.valid && in_if.ready) begin
          if (in_if.last) n_in_last++;
          if (keep == '0 && in_if.last) begin
            exp_el = 1'b1;
            n_in_empty++;
          end
          hi = -1;
          for (int k = 0; k < DOWN; k++) if (keep[k]) hi = k;
          for (int k = 0; k < DOWN; k++)
            if (keep[k]) exp_q.push_back({in_if.last && (k == hi), in_if.data[k*DWIDTH +: DWIDTH]});
        end
        if (out_if.valid && out_if.ready) begin
          if (out_if.last) n_out_last++;
          if (exp_q.size() == 0) begin
            check("unexpected_out", 1, 0);
          end else begin
            head = exp_q.pop_front();
            check("sb_data", out_if.data, head[DWIDTH-1:0]);
            check("sb_last", out_if.last, head[DWIDTH]);
          end
        end
      end
    end
  end

  // Stall stability: a pending output must not drop while blocked.
  initial begin : hold_mon
    logic stalled;
    stalled = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) stalled = 1'b0;
      else begin
        if (stalled) check("hold_valid", out_if.valid, 1);
        stalled = out_if.valid && !out_if.ready;
      end
    end
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int exp_idx[4];
    int w;
    logic accepted;
    exp_idx = '{0, 2, 5, 7};

    // reset, with an input offered during the last reset cycle
    reset = 1'b1; in_if.valid = 1'b0; in_if.last = 1'b0; in_if.data = '0;
    keep = '0; out_if.ready = 1'b1;
    repeat (3) cyc();
    drive_word(16'hEE00, 8'hFF, 1'b1);
    cyc();
    reset = 1'b0; in_if.valid = 1'b0;
    @(negedge clk);
    check("rst_valid", out_if.valid, 0);
    check("rst_last", out_if.last, 0);
    check("rst_in_ready", in_if.ready, 1);
    check("rst_empty_last", empty_last, 0);
    cyc();

    // full word, eight consecutive sub-words, last on the final one
    drive_word(16'h0000, 8'hFF, 1'b1);
    @(negedge clk); check("t1_accept", in_if.ready, 1);
    cyc(); in_if.valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t1_valid", out_if.valid, 1);
      check("t1_data", out_if.data, i);
      check("t1_last", out_if.last, (i == 7));
      cyc();
    end
    @(negedge clk); check("t1_idle", out_if.valid, 0);
    cyc();

    // sparse keep: gaps skipped, input ready only alongside the final lane
    drive_word(16'h0100, 8'hA5, 1'b0);
    @(negedge clk); check("t2_accept", in_if.ready, 1);
    cyc(); in_if.valid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check("t2_valid", out_if.valid, 1);
      check("t2_data", out_if.data, 16'h0100 + 16'(exp_idx[j]));
      check("t2_in_ready", in_if.ready, (j == 3));
      cyc();
    end
    @(negedge clk); check("t2_idle", out_if.valid, 0);
    cyc();

    // back-to-back words, no bubble
    drive_word(16'h0200, 8'h03, 1'b0);
    @(negedge clk); check("t3_accept1", in_if.ready, 1);
    cyc();
    drive_word(16'h0300, 8'h80, 1'b1);
    @(negedge clk);
    check("t3_c1_data", out_if.data, 16'h0200);
    check("t3_c1_in_ready", in_if.ready, 0);
    cyc();
    @(negedge clk);
    check("t3_c2_data", out_if.data, 16'h0201);
    check("t3_c2_in_ready", in_if.ready, 1);
    check("t3_c2_last", out_if.last, 0);
    cyc(); in_if.valid = 1'b0;
    @(negedge clk);
    check("t3_c3_valid", out_if.valid, 1);
    check("t3_c3_data", out_if.data, 16'h0307);
    check("t3_c3_last", out_if.last, 1);
    cyc();
    @(negedge clk); check("t3_idle", out_if.valid, 0);
    cyc();

    // empty words: with last -> one-cycle pulse, without -> nothing
    drive_word(16'h0500, 8'h00, 1'b1);
    @(negedge clk); check("t4_accept", in_if.ready, 1);
    cyc(); in_if.valid = 1'b0;
    @(negedge clk);
    check("t4_pulse", empty_last, 1);
    check("t4_valid", out_if.valid, 0);
    cyc();
    @(negedge clk); check("t4_pulse_end", empty_last, 0);
    cyc();
    drive_word(16'h0600, 8'h00, 1'b0);
    @(negedge clk); check("t5_accept", in_if.ready, 1);
    cyc(); in_if.valid = 1'b0;
    @(negedge clk);
    check("t5_no_pulse", empty_last, 0);
    check("t5_valid", out_if.valid, 0);
    check("t5_in_ready", in_if.ready, 1);
    cyc();

    // reset after three of eight sub-words
    drive_word(16'h0400, 8'hFF, 1'b1);
    cyc(); in_if.valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); check("t6_data", out_if.data, 16'h0400 + 16'(i));
      cyc();
    end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    @(negedge clk);
    check("t6_valid", out_if.valid, 0);
    check("t6_in_ready", in_if.ready, 1);
    check("t6_last", out_if.last, 0);
    cyc();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); check("t6_quiet", out_if.valid, 0);
      cyc();
    end

    // randomized run
    n_in_last = 0; n_in_empty = 0; n_out_last = 0; n_el = 0;
    w = 0;
    for (int c = 0; c < 30000 && w < NWORDS; c++) begin
      out_if.ready = 1'($urandom % 2);
      if (!in_if.valid && ($urandom % 4) != 0) begin
        in_if.data = {$urandom, $urandom, $urandom, $urandom};
        case ($urandom % 10)
          0:       keep = 8'h00;
          1:       keep = 8'hFF;
          default: keep = 8'($urandom);
        endcase
        in_if.last  = (($urandom % 4) == 0);
        in_if.valid = 1'b1;
      end
      @(negedge clk);
      accepted = in_if.valid && in_if.ready;
      cyc();
      if (accepted) begin
        in_if.valid = 1'b0;
        w++;
      end
    end
    check("rand_words", w, NWORDS);
    out_if.ready = 1'b1;
    for (int i = 0; i < 64 && (exp_q.size() != 0 || out_if.valid); i++) cyc();
    cyc();
    check("drain_empty", exp_q.size(), 0);
    check("empty_count", n_el, n_in_empty);
    check("last_count", n_out_last, n_in_last - n_el);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axis_keep_downsizer.md
AXIS_KEEP_DOWNSIZER -- requirements
Module: axis_keep_downsizer

Interface
REQ-001 The block SHALL have parameter DWIDTH, default 16, giving the output sub-word width in bits.
REQ-002 The block SHALL have parameter DOWN, default 8, giving the number of sub-words per input word (DOWN >= 2).
REQ-003 The block SHALL have port clk, input, 1 bit, clock.
REQ-004 The block SHALL have port reset, input, 1 bit, reset (synchronous, active-high).
REQ-005 The block SHALL have port data_in, Axis_If.Slave_Full, DWIDTH*DOWN bits, packed input words; sub-word k is bits [k*DWIDTH +: DWIDTH].
REQ-006 The block SHALL have port data_in_keep, input, DOWN bits, per-sub-word valid mask, sampled only when data_in.ok.
REQ-007 The block SHALL have port data_out, Axis_If.Master_Full, DWIDTH bits, kept sub-words in ascending index order.
REQ-008 The block SHALL have port empty_last, output, 1 bit, one-cycle pulse flagging an all-zero-keep word that carried last.

Function
REQ-009 The block SHALL hold one word: data_reg (DOWN x DWIDTH), mask_reg (DOWN bits) and last_reg.
REQ-010 The block SHALL drive data_in.ready = (mask_reg == 0) | (final & data_out.ready), where final = exactly one bit of mask_reg is set.
REQ-011 On data_in.ok the block SHALL load data_reg <= data_in.data, mask_reg <= data_in_keep and last_reg <= data_in.last.
REQ-012 The block SHALL drive data_out.valid = |mask_reg.
REQ-013 The block SHALL drive data_out.data = data_reg[idx], where idx = index of the lowest set bit of mask_reg.
REQ-014 The block SHALL drive data_out.last = last_reg & final & |mask_reg.
REQ-015 On data_out.ok without a simultaneous load, the block SHALL clear bit idx of mask_reg.
REQ-016 On a simultaneous data_out.ok of the final sub-word and data_in.ok, the load SHALL take priority, so the new word's first sub-word is valid the next cycle with no bubble.
REQ-017 Latency SHALL be one cycle from input acceptance to the first output valid.
REQ-018 Sustained throughput SHALL be one sub-word per cycle while data_out.ready is high; a word with N kept sub-words SHALL occupy exactly N output cycles.
REQ-019 Gaps in keep (e.g. 0b1010_0101) SHALL be skipped with no idle output cycles.
REQ-020 A word with data_in_keep == 0 and last == 0 SHALL be accepted and silently dropped; data_in.ready stays high.
REQ-021 A word with data_in_keep == 0 and last == 1 SHALL be accepted with no output transfer, and empty_last SHALL pulse high in the following cycle.
REQ-022 While data_out.valid is high and data_out.ready is low, data_out.data, data_out.valid and data_out.last SHALL be held stable.
REQ-023 Sub-word contents at positions with keep = 0 SHALL never appear on data_out.

Reset
REQ-024 While reset is high, mask_reg, data_reg, last_reg and empty_last SHALL all be cleared to 0.
REQ-025 Following from REQ-024, data_out.valid = 0, data_out.last = 0 and data_in.ready = 1 in the cycle after reset.
REQ-026 Reset asserted mid-word SHALL discard the remaining sub-words with no partial last emitted.
REQ-027 A data_in.ok in the same cycle as reset SHALL be ignored.

Structure
REQ-028 Lowest-set-bit and one-hot-check functions SHALL live in the shared axis processing package so other keep-aware blocks reuse them.
REQ-029 The priority encoder SHALL be a sub-module named lsb_priority_encoder (parameter N; outputs idx, any, single).
REQ-030 No further sub-modules SHALL be used.
REQ-031 All state SHALL be in one always_ff block with reset first.

Verification
REQ-032 The bench SHALL cover: DOWN=8, keep=0xFF, data 0x0007..0x0000 sub-words, last=1, ready high -> 8 transfers 0x0000..0x0007 on consecutive cycles, last only on 0x0007.
REQ-033 The bench SHALL cover: keep=0xA5 -> outputs sub-words 0,2,5,7 in 4 consecutive cycles; data_in.ready high only in the cycle of sub-word 7.
REQ-034 The bench SHALL cover: back-to-back words keep=0x03 then 0x80 with ready high -> 3 output cycles with no bubble; new word accepted in the same cycle sub-word 1 is taken.
REQ-035 The bench SHALL cover: keep=0x00, last=1 -> no data_out.valid, empty_last high exactly one cycle; a keep=0x00, last=0 word -> no output and no pulse.
REQ-036 The bench SHALL cover: random data_out.ready (50%) and random data_in.valid over 1000 words -> output stream equals the reference model's kept sub-words in order, with last count equal to the input last count minus the empty_last count.
REQ-037 The bench SHALL cover: reset asserted after 3 of 8 sub-words -> next cycle data_out.valid=0, data_in.ready=1, and no further sub-words from that word.
